sipo_frame_ctrl: RTL

- Controller that sequences a serial-in/parallel-out shift stage into framed words.
- Accepts a start strobe, counts exactly WIDTH qualified serial bits and latches the assembled word.
- Presents the word downstream on a valid/ready handshake and flags protocol violations.
- Sits between a single-wire serial source and a parallel consumer. Replaces free-running shifting with framed, counted capture.

---
 rtl/sipo_frame_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sipo_frame_ctrl.sv
// Framed serial-in/parallel-out capture: counts qualified bits after a start strobe and hands
// the word off on valid/ready. Define SIPO_FRAME_PARITY_EN to add an even-parity trailer bit.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             x_i,
  input  logic             x_valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             overrun_o,
`ifdef SIPO_FRAME_PARITY_EN
  output logic             parity_err_o,
`endif
  output logic [7:0]       frame_cnt_o
);

  localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SIPO_FRAME_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(NBITS - 1);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovr_q, ovr_d;
  logic [7:0]         fcnt_q, fcnt_d;
`ifdef SIPO_FRAME_PARITY_EN
  logic               par_q, par_d;
  logic               perr_q, perr_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      fcnt_q  <= '0;
`ifdef SIPO_FRAME_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      fcnt_q  <= fcnt_d;
`ifdef SIPO_FRAME_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // The shift register doubles as the output word: it is frozen while in HOLD.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    fcnt_d  = fcnt_q;
`ifdef SIPO_FRAME_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
`ifdef SIPO_FRAME_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          sr_d    = '0;
`ifdef SIPO_FRAME_PARITY_EN
          par_d   = 1'b0;
`endif
        end else if (x_valid_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q < DATA_BITS) begin
            sr_d = {sr_q[WIDTH-2:0], x_i};
          end
`ifdef SIPO_FRAME_PARITY_EN
          par_d = par_q ^ x_i;
`endif
          if (cnt_q == LAST_BIT) begin
            state_d = HOLD;
            cnt_d   = '0;
`ifdef SIPO_FRAME_PARITY_EN
            perr_d  = par_q ^ x_i;
`endif
          end
        end
      end
      HOLD: begin
        if (x_valid_i) begin
          ovr_d = 1'b1;
        end
        if (ready_i) begin
          fcnt_d  = fcnt_q + 8'd1;
          cnt_d   = '0;
          state_d = start_i ? SHIFT : IDLE;
`ifdef SIPO_FRAME_PARITY_EN
          par_d   = 1'b0;
          perr_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_o      = sr_q;
  assign valid_o     = (state_q == HOLD);
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = ovr_q;
  assign frame_cnt_o = fcnt_q;
`ifdef SIPO_FRAME_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule
